// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the two-input stream arbiter.
//   SRC0 / SRC1 : source-index constants used for grants and y_sel
//   LAST_RST    : reset value of the round-robin history register
//   grant_t     : combinational grant (valid flag plus winning source index)
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam logic SRC0     = 1'b0;
    localparam logic SRC1     = 1'b1;
    // Pretending source 1 was served last makes source 0 win the first contention.
    localparam logic LAST_RST = SRC1;

    typedef struct packed {
        logic vld;
        logic idx;
    } grant_t;

endpackage

// File: rtl/mux_2_1.sv
// -----------------------------------------------------------------------------
// mux_2_1
// Single-bit 2:1 select.
//   sel : 0 selects i0, 1 selects i1
//   i0  : input 0
//   i1  : input 1
//   y   : selected value
// -----------------------------------------------------------------------------
module mux_2_1 (
    input  logic sel,
    input  logic i0,
    input  logic i1,
    output logic y
);

    assign y = sel ? i1 : i0;

endmodule

// File: rtl/arb_mux_2_1.sv
// -----------------------------------------------------------------------------
// arb_mux_2_1
// Two-input round-robin stream arbiter feeding a single registered output.
// The winning source drives the select of a bank of mux_2_1 cells and the
// selected word is captured in the output register.
//
// Parameters:
//   WIDTH     : data width of each source and of the output
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous, active-high reset
//   i0_valid  : source 0 has a word        i0_data : source 0 word
//   i0_ready  : source 0 word accepted this cycle
//   i1_valid  : source 1 has a word        i1_data : source 1 word
//   i1_ready  : source 1 word accepted this cycle
//   y_valid   : output register holds a word
//   y_data    : output word
//   y_sel     : index of the source that produced y_data
//   y_ready   : consumer accepts y_data this cycle
//
// Build option:
//   ARB_FIXED_PRIO_EN : when defined, source 0 always wins contention and no
//                       round-robin history is kept. Default is round-robin.
// -----------------------------------------------------------------------------
module arb_mux_2_1
    import arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i0_valid,
    input  logic [WIDTH-1:0] i0_data,
    output logic             i0_ready,
    input  logic             i1_valid,
    input  logic [WIDTH-1:0] i1_data,
    output logic             i1_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    output logic             y_sel,
    input  logic             y_ready
);

    grant_t           gnt;
    logic             load;
    logic [WIDTH-1:0] mux_y;

    // Output stage can accept when empty or being drained on this same edge.
    assign load = !y_valid || y_ready;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        gnt.vld = i0_valid || i1_valid;
        gnt.idx = i0_valid ? SRC0 : SRC1;
    end
`else
    logic last;

    always_comb begin
        gnt.vld = i0_valid || i1_valid;
        if (i0_valid && i1_valid) begin
            gnt.idx = ~last;
        end else if (i1_valid) begin
            gnt.idx = SRC1;
        end else begin
            gnt.idx = SRC0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= LAST_RST;
        end else if (load && gnt.vld) begin
            last <= gnt.idx;
        end
    end
`endif

    // Readies are held low during reset so no word is consumed and then discarded.
    assign i0_ready = !rst && load && gnt.vld && (gnt.idx == SRC0);
    assign i1_ready = !rst && load && gnt.vld && (gnt.idx == SRC1);

    for (genvar b = 0; b < WIDTH; b++) begin : g_mux
        mux_2_1 u_mux (
            .sel (gnt.idx),
            .i0  (i0_data[b]),
            .i1  (i1_data[b]),
            .y   (mux_y[b])
        );
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            y_valid <= 1'b0;
            y_data  <= '0;
            y_sel   <= SRC0;
        end else if (load) begin
            if (gnt.vld) begin
                y_valid <= 1'b1;
                y_data  <= mux_y;
                y_sel   <= gnt.idx;
            end else begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux_2_1.sv
module tb_arb_mux_2_1;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         i0_valid, i1_valid, y_ready;
    logic [W-1:0] i0_data, i1_data;
    logic         i0_ready, i1_ready, y_valid, y_sel;
    logic [W-1:0] y_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    arb_mux_2_1 #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .i0_valid (i0_valid),
        .i0_data  (i0_data),
        .i0_ready (i0_ready),
        .i1_valid (i1_valid),
        .i1_data  (i1_data),
        .i1_ready (i1_ready),
        .y_valid  (y_valid),
        .y_data   (y_data),
        .y_sel    (y_sel),
        .y_ready  (y_ready)
    );

    typedef struct {
        logic         rst;
        logic         v0;
        logic [W-1:0] d0;
        logic         v1;
        logic [W-1:0] d1;
        logic         yr;
        logic         r0;
        logic         r1;
        logic         yv;
        logic [W-1:0] yd;
        logic         ys;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic v0, input logic [W-1:0] d0,
                       input logic v1, input logic [W-1:0] d1, input logic yr,
                       input logic r0, input logic r1,
                       input logic yv, input logic [W-1:0] yd, input logic ys);
        vec_t v;
        v.rst = r;  v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.yr = yr;
        v.r0 = r0;  v.r1 = r1; v.yv = yv; v.yd = yd; v.ys = ys;
        tbl.push_back(v);
    endtask

    // Reference model: the output slot plus a "preferred source" pointer that
    // names who wins the next tie.
    logic         m_v, m_s;
    logic [W-1:0] m_d;
    int           m_pref;

    task automatic model_reset();
        m_v = 1'b0; m_d = '0; m_s = 1'b0; m_pref = 0;
    endtask

    // Returns which source (if any) the model expects to be accepted now.
    task automatic model_eval(input logic r, input logic v0, input logic v1, input logic yr,
                              output logic e0, output logic e1);
        int  w;
        bit  room;
        room = !m_v || yr;
        if (v0 && v1) w = m_pref;
        else if (v0)  w = 0;
        else if (v1)  w = 1;
        else          w = -1;
        e0 = !r && room && (w == 0);
        e1 = !r && room && (w == 1);
    endtask

    task automatic model_step(input logic r, input logic v0, input logic [W-1:0] d0,
                              input logic v1, input logic [W-1:0] d1, input logic yr);
        logic e0, e1;
        model_eval(r, v0, v1, yr, e0, e1);
        if (r) begin
            model_reset();
        end else if (!m_v || yr) begin
            if (e0 || e1) begin
                m_v = 1'b1;
                m_d = e1 ? d1 : d0;
                m_s = e1;
`ifndef ARB_FIXED_PRIO_EN
                m_pref = e1 ? 0 : 1;
`endif
            end else begin
                m_v = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic r, input logic v0, input logic [W-1:0] d0,
                         input logic v1, input logic [W-1:0] d1, input logic yr);
        rst = r; i0_valid = v0; i0_data = d0; i1_valid = v1; i1_data = d1; y_ready = yr;
    endtask

    logic         p0, p1;
    logic [W-1:0] q0, q1;
    logic         rr, ryr, e0, e1;

    initial begin
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);

        // Reset with both sources valid
        add(1, 1, 8'hAA, 1, 8'hBB, 1,  0, 0,  0, 8'h00, 0);
        add(1, 1, 8'hAA, 1, 8'hBB, 1,  0, 0,  0, 8'h00, 0);
        // Contention: first tie goes to source 0
        add(0, 1, 8'hA0, 1, 8'hB0, 1,  1, 0,  1, 8'hA0, 0);
`ifdef ARB_FIXED_PRIO_EN
        add(0, 1, 8'hA1, 1, 8'hB0, 1,  1, 0,  1, 8'hA1, 0);
        add(0, 1, 8'hA2, 1, 8'hB0, 1,  1, 0,  1, 8'hA2, 0);
        add(0, 1, 8'hA3, 1, 8'hB0, 1,  1, 0,  1, 8'hA3, 0);
`else
        add(0, 1, 8'hA1, 1, 8'hB0, 1,  0, 1,  1, 8'hB0, 1);
        add(0, 1, 8'hA1, 1, 8'hB1, 1,  1, 0,  1, 8'hA1, 0);
        add(0, 1, 8'hA2, 1, 8'hB1, 1,  0, 1,  1, 8'hB1, 1);
`endif
        // Single source back-to-back, then idle (data holds)
        add(0, 1, 8'h11, 0, 8'h00, 1,  1, 0,  1, 8'h11, 0);
        add(0, 1, 8'h22, 0, 8'h00, 1,  1, 0,  1, 8'h22, 0);
        add(0, 1, 8'h33, 0, 8'h00, 1,  1, 0,  1, 8'h33, 0);
        add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0,  0, 8'h33, 0);
        // Back-pressure holding 0x5A for 3 cycles, then drain and fill together
        add(0, 1, 8'h5A, 0, 8'h00, 1,  1, 0,  1, 8'h5A, 0);
        add(0, 1, 8'h66, 1, 8'h77, 0,  0, 0,  1, 8'h5A, 0);
        add(0, 1, 8'h66, 1, 8'h77, 0,  0, 0,  1, 8'h5A, 0);
        add(0, 1, 8'h66, 1, 8'h77, 0,  0, 0,  1, 8'h5A, 0);
`ifdef ARB_FIXED_PRIO_EN
        add(0, 1, 8'h66, 1, 8'h77, 1,  1, 0,  1, 8'h66, 0);
        add(0, 1, 8'h67, 1, 8'h77, 1,  1, 0,  1, 8'h67, 0);
`else
        add(0, 1, 8'h66, 1, 8'h77, 1,  0, 1,  1, 8'h77, 1);
        add(0, 1, 8'h66, 0, 8'h00, 1,  1, 0,  1, 8'h66, 0);
`endif
        // Mid-stream reset drops the held word and restores source-0 priority
        add(1, 1, 8'h99, 1, 8'h98, 0,  0, 0,  0, 8'h00, 0);
        add(0, 1, 8'h99, 1, 8'h98, 1,  1, 0,  1, 8'h99, 0);
        add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0,  0, 8'h99, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].yr);
            #1;
            chk($sformatf("vec%0d_i0_ready", i), {31'b0, i0_ready}, {31'b0, tbl[i].r0});
            chk($sformatf("vec%0d_i1_ready", i), {31'b0, i1_ready}, {31'b0, tbl[i].r1});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_y_valid", i), {31'b0, y_valid}, {31'b0, tbl[i].yv});
            chk($sformatf("vec%0d_y_data", i),  {24'b0, y_data},  {24'b0, tbl[i].yd});
            chk($sformatf("vec%0d_y_sel", i),   {31'b0, y_sel},   {31'b0, tbl[i].ys});
        end

        // Randomized protocol-respecting traffic against the reference model
        @(negedge clk);
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        @(posedge clk);
        model_reset();
        p0 = 1'b0; p1 = 1'b0; q0 = '0; q1 = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("rnd_y_valid", {31'b0, y_valid}, {31'b0, m_v});
            chk("rnd_y_data",  {24'b0, y_data},  {24'b0, m_d});
            chk("rnd_y_sel",   {31'b0, y_sel},   {31'b0, m_s});
            rr  = ($urandom_range(0, 99) == 0);
            ryr = ($urandom_range(0, 3) != 0);
            if (!p0 && $urandom_range(0, 3) != 0) begin p0 = 1'b1; q0 = W'($urandom); end
            if (!p1 && $urandom_range(0, 3) != 0) begin p1 = 1'b1; q1 = W'($urandom); end
            drive(rr, p0, q0, p1, q1, ryr);
            #1;
            model_eval(rr, p0, p1, ryr, e0, e1);
            chk("rnd_i0_ready", {31'b0, i0_ready}, {31'b0, e0});
            chk("rnd_i1_ready", {31'b0, i1_ready}, {31'b0, e1});
            model_step(rr, p0, q0, p1, q1, ryr);
            if (e0) p0 = 1'b0;
            if (e1) p1 = 1'b0;
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
